// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: RGB565 test-pattern source for a 240x135 ST7789 SPI LCD driver.
// Pixels are produced in raster order, one per pix_valid/pix_ready transfer.
// Patterns: colour bars, checkerboard, gradient and a solid colour.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   enable              level; start/continue frame generation
//   mode, solid_color   pattern select and solid colour, sampled only at frame start
//   pix_valid/ready     pixel handshake
//   pix_data            RGB565 pixel, MSB = red[4]
//   pix_sof/eol/eof     first pixel, last pixel of line, last pixel of frame
//   frame_cnt           completed frames, wrapping
//   busy                generator is in the RUN state
//
// Optional build macro: LCD_PATGEN_SCROLL_EN adds a per-frame horizontal scroll for
// the bar and checker patterns.
module lcd_pattern_gen #(
  parameter int unsigned H_RES    = 240,
  parameter int unsigned V_RES    = 135,
  parameter int unsigned CHK_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic [7:0]  frame_cnt,
  output logic        busy
);

  localparam int unsigned BarW  = H_RES / 8;
  localparam logic [7:0]  XLast = 8'(H_RES - 1);
  localparam logic [7:0]  YLast = 8'(V_RES - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  fc_q, fc_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] color_q, color_d;
  logic [7:0]  px;
  logic        run, last_x, last_pix;

  assign run      = (state_q == StRun);
  assign last_x   = (x_q == XLast);
  assign last_pix = last_x && (y_q == YLast);

`ifdef LCD_PATGEN_SCROLL_EN
  logic [7:0] scroll_q, scroll_d;
  logic [8:0] px_sum;

  // Scrolled column, folded back into 0..H_RES-1 without a modulo.
  assign px_sum = {1'b0, x_q} + {1'b0, scroll_q};
  assign px     = (px_sum >= 9'(H_RES)) ? 8'(px_sum - 9'(H_RES)) : px_sum[7:0];
`else
  assign px = x_q;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    fc_d    = fc_q;
    mode_d  = mode_q;
    color_d = color_q;
`ifdef LCD_PATGEN_SCROLL_EN
    scroll_d = scroll_q;
`endif
    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StRun;
          mode_d  = mode;
          color_d = solid_color;
          x_d     = '0;
          y_d     = '0;
        end
      end
      StRun: begin
        if (pix_ready) begin
          if (!last_x) begin
            x_d = x_q + 8'd1;
          end else if (!last_pix) begin
            x_d = '0;
            y_d = y_q + 8'd1;
          end else begin
            x_d  = '0;
            y_d  = '0;
            fc_d = fc_q + 8'd1;
`ifdef LCD_PATGEN_SCROLL_EN
            scroll_d = (scroll_q == XLast) ? 8'd0 : scroll_q + 8'd1;
`endif
            // Frame boundary: relatch settings or stop; enable is ignored mid-frame.
            if (enable) begin
              mode_d  = mode;
              color_d = solid_color;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      fc_q     <= '0;
      mode_q   <= '0;
      color_q  <= '0;
`ifdef LCD_PATGEN_SCROLL_EN
      scroll_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      fc_q     <= fc_d;
      mode_q   <= mode_d;
      color_q  <= color_d;
`ifdef LCD_PATGEN_SCROLL_EN
      scroll_q <= scroll_d;
`endif
    end
  end

  // Bar index by threshold comparison; 8 means past the last full bar.
  logic [3:0]  bar;
  logic [15:0] bar_color;
  logic [7:0]  chk_v;
  logic [15:0] pattern;

  always_comb begin
    bar = 4'd0;
    for (int unsigned k = 1; k <= 8; k++) begin
      if ({1'b0, px} >= 9'(k * BarW)) bar = bar + 4'd1;
    end
    case (bar)
      4'd0:    bar_color = 16'hFFFF;
      4'd1:    bar_color = 16'hFFE0;
      4'd2:    bar_color = 16'h07FF;
      4'd3:    bar_color = 16'h07E0;
      4'd4:    bar_color = 16'hF81F;
      4'd5:    bar_color = 16'hF800;
      4'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  end

  assign chk_v = (px >> CHK_LOG2) ^ (y_q >> CHK_LOG2);

  always_comb begin
    case (mode_q)
      2'd0:    pattern = bar_color;
      2'd1:    pattern = chk_v[0] ? 16'hFFFF : 16'h0000;
      2'd2:    pattern = {x_q[7:3], y_q[7:2], fc_q[4:0]};
      default: pattern = color_q;
    endcase
  end

  // All outputs derive from registered state only; markers are zero outside RUN.
  assign pix_valid = run;
  assign busy      = run;
  assign pix_data  = run ? pattern : 16'h0000;
  assign pix_sof   = run && (x_q == 8'd0) && (y_q == 8'd0);
  assign pix_eol   = run && last_x;
  assign pix_eof   = run && last_pix;
  assign frame_cnt = fc_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Self-checking bench for lcd_pattern_gen, run at a reduced 43x20 resolution so that many
// frames fit in a short run; 43 columns leaves 3 columns past the last full colour bar.
module tb_lcd_pattern_gen;

  localparam int H     = 43;
  localparam int V     = 20;
  localparam int C     = 4;
  localparam int FRAME = H * V;
  localparam int BW    = H / 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] solid_color = 16'h0000;
  logic        pix_ready = 1'b0;
  logic        pix_valid, pix_sof, pix_eol, pix_eof, busy;
  logic [15:0] pix_data;
  logic [7:0]  frame_cnt;

  lcd_pattern_gen #(.H_RES(H), .V_RES(V), .CHK_LOG2(C)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .solid_color (solid_color),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_sof     (pix_sof),
    .pix_eol     (pix_eol),
    .pix_eof     (pix_eof),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: frame position kept as a linear pixel index.
  bit          m_run;
  int          m_idx, m_fc, m_scroll;
  logic [1:0]  m_mode;
  logic [15:0] m_color;

  logic [15:0] fbuf [FRAME];
  logic [15:0] ref0 [FRAME];

  typedef struct {
    int          fid;
    int          x;
    int          y;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] bar_rgb(input int b);
    case (b)
      0:       return 16'hFFFF;
      1:       return 16'hFFE0;
      2:       return 16'h07FF;
      3:       return 16'h07E0;
      4:       return 16'hF81F;
      5:       return 16'hF800;
      6:       return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] model_pix(input int idx);
    int x, y, px;
    x  = idx % H;
    y  = idx / H;
    px = x;
`ifdef LCD_PATGEN_SCROLL_EN
    px = (x + m_scroll) % H;
`endif
    case (m_mode)
      2'd0:    return bar_rgb(px / BW);
      2'd1:    return ((((px >> C) ^ (y >> C)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      2'd2:    return 16'((((x >> 3) & 31) << 11) | (((y >> 2) & 63) << 5) | (m_fc & 31));
      default: return m_color;
    endcase
  endfunction

  task automatic model_reset();
    m_run = 0; m_idx = 0; m_fc = 0; m_scroll = 0; m_mode = 2'd0; m_color = 16'h0;
  endtask

  task automatic check_outputs(input string name);
    logic [28:0] act, exp;
    act = {pix_valid, busy, pix_sof, pix_eol, pix_eof, frame_cnt, pix_data};
    exp = {m_run, m_run, m_run && m_idx == 0, m_run && (m_idx % H) == H - 1,
           m_run && m_idx == FRAME - 1, 8'(m_fc), m_run ? model_pix(m_idx) : 16'h0000};
    chk(name, 64'(act), 64'(exp));
  endtask

  // Apply inputs for the coming edge, advance the model, then compare just after the edge.
  task automatic step(input logic en, input logic rdy, input logic [1:0] md,
                      input logic [15:0] sc);
    enable = en; pix_ready = rdy; mode = md; solid_color = sc;
    if (reset) begin
      model_reset();
    end else if (!m_run) begin
      if (en) begin m_run = 1; m_mode = md; m_color = sc; m_idx = 0; end
    end else if (rdy) begin
      if (m_idx == FRAME - 1) begin
        m_idx = 0;
        m_fc = (m_fc + 1) % 256;
        m_scroll = (m_scroll + 1) % H;
        if (en) begin m_mode = md; m_color = sc; end
        else m_run = 0;
      end else begin
        m_idx++;
      end
    end
    @(posedge clk); #1;
    check_outputs("stream");
  endtask

  // Streams one whole frame; settings switch to md2/sc2 from pixel sw_at on, enable drops
  // from pixel drop_at on (negative = never).
  task automatic run_frame(input logic [1:0] md, input logic [15:0] sc, input logic [1:0] md2,
                           input logic [15:0] sc2, input int sw_at, input int rdy_pct,
                           input int drop_at);
    int  guard, xfers;
    bit  done;
    logic r, e;
    guard = 0; xfers = 0; done = 0;
    while (!done && guard < 8 * FRAME) begin
      r = ($urandom_range(99) < rdy_pct);
      e = !(drop_at >= 0 && m_idx >= drop_at);
      if (m_run && r) begin
        fbuf[m_idx] = pix_data;
        xfers++;
        if (m_idx == FRAME - 1) done = 1;
      end
      if (m_idx >= sw_at) step(e, r, md2, sc2);
      else step(e, r, md, sc);
      guard++;
    end
    chk("frame_done", 64'(done), 64'(1));
    chk("frame_xfers", 64'(xfers), 64'(FRAME));
  endtask

  task automatic apply_table(input int fid);
    foreach (vecs[i]) begin
      if (vecs[i].fid == fid)
        chk($sformatf("table_f%0d_x%0d_y%0d", fid, vecs[i].x, vecs[i].y),
            64'(fbuf[vecs[i].y * H + vecs[i].x]), 64'(vecs[i].exp));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Frame 0: bars (bar width 5, columns 40..42 black)
    vecs.push_back('{0, 0, 0, 16'hFFFF});  vecs.push_back('{0, 5, 0, 16'hFFE0});
    vecs.push_back('{0, 14, 3, 16'h07FF}); vecs.push_back('{0, 15, 3, 16'h07E0});
    vecs.push_back('{0, 20, 7, 16'hF81F}); vecs.push_back('{0, 29, 7, 16'hF800});
    vecs.push_back('{0, 34, 0, 16'h001F}); vecs.push_back('{0, 35, 0, 16'h0000});
    vecs.push_back('{0, 40, 0, 16'h0000}); vecs.push_back('{0, 42, 19, 16'h0000});
    // Frame 2: gradient with frame_cnt = 2
    vecs.push_back('{2, 0, 0, 16'h0002});  vecs.push_back('{2, 8, 4, 16'h0822});
    vecs.push_back('{2, 42, 19, 16'h2882});
    // Frame 4: solid F800 despite colour change at pixel 100
    vecs.push_back('{4, 0, 0, 16'hF800});  vecs.push_back('{4, 13, 2, 16'hF800});
    vecs.push_back('{4, 14, 2, 16'hF800}); vecs.push_back('{4, 42, 19, 16'hF800});
    // Frame 5: the colour latched at the previous frame boundary
    vecs.push_back('{5, 0, 0, 16'h001F});  vecs.push_back('{5, 42, 19, 16'h001F});
    // Frame 6: checker right after a reset
    vecs.push_back('{6, 0, 0, 16'h0000});  vecs.push_back('{6, 16, 0, 16'hFFFF});
    vecs.push_back('{6, 16, 16, 16'h0000}); vecs.push_back('{6, 15, 17, 16'hFFFF});
    vecs.push_back('{6, 32, 0, 16'h0000}); vecs.push_back('{6, 42, 19, 16'hFFFF});

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_state");
    reset = 1'b0;
    repeat (2) step(1'b0, 1'b1, 2'd0, 16'h0);

    run_frame(2'd0, 16'h0, 2'd1, 16'h0, FRAME - 1, 100, -1);
    apply_table(0);
    chk("frame_cnt_after_f0", 64'(frame_cnt), 64'(1));
    run_frame(2'd1, 16'h0, 2'd2, 16'h0, FRAME - 1, 100, -1);
    run_frame(2'd2, 16'h0, 2'd0, 16'h0, FRAME - 1, 100, -1);
    apply_table(2);
    run_frame(2'd0, 16'h0, 2'd3, 16'hF800, FRAME - 1, 50, -1);
    run_frame(2'd3, 16'hF800, 2'd3, 16'h001F, 100, 100, -1);
    apply_table(4);
    run_frame(2'd3, 16'h001F, 2'd3, 16'h001F, FRAME, 100, 500);
    apply_table(5);
    repeat (3) step(1'b0, 1'b1, 2'd0, 16'h0);
    chk("idle_valid", 64'(pix_valid), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_frame_cnt", 64'(frame_cnt), 64'(6));

    // Asynchronous reset part-way through a frame
    begin
      int g;
      g = 0;
      while ((!m_run || m_idx < 200) && g < 1000) begin
        step(1'b1, 1'b1, 2'd0, 16'h0);
        g++;
      end
      chk("reached_pixel_200", 64'(m_idx), 64'(200));
    end
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("reset_async");
    chk("reset_data", 64'(pix_data), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    run_frame(2'd1, 16'h0, 2'd1, 16'h0, FRAME, 100, FRAME - 1);
    apply_table(6);
    chk("frame_cnt_after_reset", 64'(frame_cnt), 64'(1));

`ifdef LCD_PATGEN_SCROLL_EN
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int f = 0; f <= H; f++) begin
      run_frame(2'd0, 16'h0, 2'd0, 16'h0, FRAME, 100, (f == H) ? FRAME - 1 : -1);
      if (f == 0) begin
        chk("scroll_f0_x0", 64'(fbuf[0]), 64'(16'hFFFF));
        foreach (fbuf[i]) ref0[i] = fbuf[i];
      end
      if (f == 1) chk("scroll_f1_bar1", 64'(fbuf[BW - 1]), 64'(16'hFFE0));
    end
    begin
      int diff;
      diff = 0;
      foreach (fbuf[i]) if (fbuf[i] != ref0[i]) diff++;
      chk("scroll_wrap_equals_f0", 64'(diff), 64'(0));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
